// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   dcnt_q, dcnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BeW-1:0]    mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;

  logic if_vld, d_vld, grant_d, grant_if, done;

  // A request seen in its own ack cycle belongs to the finished transaction.
  assign if_vld   = if_req && !if_ack_q;
  assign d_vld    = d_req && !d_ack_q;
  assign grant_d  = d_vld && !(if_vld && (dcnt_q == CntMax));
  assign grant_if = !grant_d && if_vld;
  assign done     = mem_req_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d     = StData;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            dcnt_d = '0;
          end else if (dcnt_q != CntMax) begin
            dcnt_d = dcnt_q + CntW'(1);
          end
        end else if (grant_if) begin
          state_d     = StFetch;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          dcnt_d      = '0;
        end
      end
      StFetch: begin
        if (done) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      StData: begin
        if (done) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level model.
// The DUT is built with STARVE_MAX=2 so starvation kicks in quickly.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic          if_ack, d_ack, mem_req, mem_we, busy;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data), the issued access, results.
  int            m_owner;
  int            m_streak;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
  logic          m_if_ack, m_d_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    m_if_rdata = 0; m_d_rdata = 0; m_if_ack = 0; m_d_ack = 0;
  endtask

  // Applies the arbitration rules to the inputs present just before an edge.
  task automatic model_step();
    bit if_seen, d_seen, take_d;
    bit next_if_ack = 0, next_d_ack = 0;
    if_seen = if_req && !m_if_ack;
    d_seen  = d_req && !m_d_ack;
    if (m_owner != 0) begin
      if (mem_ready) begin
        if (m_owner == 1) begin
          m_if_rdata = mem_rdata; next_if_ack = 1;
        end else begin
          if (!m_we) m_d_rdata = mem_rdata;
          next_d_ack = 1;
        end
        m_owner = 0;
      end
    end else begin
      take_d = d_seen && !(if_seen && m_streak == SM);
      if (take_d) begin
        m_owner = 2; m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = if_req ? ((m_streak < SM) ? m_streak + 1 : m_streak) : 0;
      end else if (if_seen) begin
        m_owner = 1; m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = 0;
        m_streak = 0;
      end
    end
    m_if_ack = next_if_ack;
    m_d_ack  = next_d_ack;
  endtask

  task automatic check_all();
    check("mem_req", 64'(mem_req), 64'(m_owner != 0));
    check("busy", 64'(busy), 64'(m_owner != 0));
    check("if_ack", 64'(if_ack), 64'(m_if_ack));
    check("d_ack", 64'(d_ack), 64'(m_d_ack));
    check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
    check("d_rdata", 64'(d_rdata), 64'(m_d_rdata));
    if (m_owner != 0) begin
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_be", 64'(mem_be), 64'(m_be));
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [AW-1:0] exp_seq [6];
    logic [DW-1:0] last_load;
    int grants, budget;
    logic prev_req;

    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_ready = 0;
    model_reset();
    #3;
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    #4 rst = 0;

    // Fetch, zero wait; mem_ready high while idle must not matter.
    if_req = 1; if_addr = 32'h10; mem_rdata = 32'h0050_0093; mem_ready = 1;
    cycle();
    check("fetch_mem_req", 64'(mem_req), 64'd1);
    check("fetch_mem_addr", 64'(mem_addr), 64'h10);
    check("fetch_mem_we", 64'(mem_we), 64'd0);
    check("fetch_mem_be", 64'(mem_be), 64'hF);
    cycle();
    check("fetch_ack", 64'(if_ack), 64'd1);
    check("fetch_rdata", 64'(if_rdata), 64'h0050_0093);
    if_req = 0;
    cycle();

    // Load with three wait states.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; mem_ready = 0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      mem_rdata = $urandom;
      cycle();
      check("wait_addr", 64'(mem_addr), 64'h200);
      check("wait_no_ack", 64'(d_ack), 64'd0);
    end
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    cycle();
    check("wait_ack", 64'(d_ack), 64'd1);
    check("wait_rdata", 64'(d_rdata), 64'hCAFE_0001);
    last_load = 32'hCAFE_0001;
    d_req = 0;
    cycle();

    // Collision: store goes first, fetch granted in the store's ack cycle.
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    cycle();
    check("coll_be", 64'(mem_be), 64'h3);
    check("coll_addr", 64'(mem_addr), 64'h100);
    check("coll_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    cycle();
    check("coll_d_ack", 64'(d_ack), 64'd1);
    check("coll_d_rdata", 64'(d_rdata), 64'(last_load));
    d_req = 0;
    cycle();
    check("coll_fetch_addr", 64'(mem_addr), 64'h20);
    check("coll_fetch_req", 64'(mem_req), 64'd1);
    cycle();
    check("coll_if_ack", 64'(if_ack), 64'd1);

    // Ack mask: if_req kept high through its ack cycle.
    cycle();
    check("mask_no_grant", 64'(mem_req), 64'd0);
    check("mask_busy", 64'(busy), 64'd0);
    if_req = 0;
    cycle();
    cycle();

    // Starvation: fetch pending except during data ack cycles -> D,D,F,D,D,F.
    exp_seq = '{32'h8000, 32'h8000, 32'h4000, 32'h8000, 32'h8000, 32'h4000};
    if_req = 1; if_addr = 32'h4000;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h8000; mem_ready = 1;
    grants = 0; budget = 0; prev_req = 0;
    while (grants < 6 && budget < 60) begin
      cycle();
      budget++;
      if (mem_req && !prev_req) begin
        check("starve_order", 64'(mem_addr), 64'(exp_seq[grants]));
        grants++;
      end
      prev_req = mem_req;
      if_req = !m_d_ack;
    end
    check("starve_grants", 64'(grants), 64'd6);
    if_req = 0; d_req = 0;
    repeat (4) cycle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (!if_req || m_if_ack) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || m_d_ack) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) != 0;
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      cycle();
      check("one_ack", 64'(if_ack && d_ack), 64'd0);
    end

    // Reset in the first cycle of a data access.
    if_req = 0; d_req = 0;
    repeat (6) begin
      mem_ready = 1;
      cycle();
    end
    d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 0;
    cycle();
    check("rst_pre_req", 64'(mem_req), 64'd1);
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_acks", 64'({if_ack, d_ack}), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    d_req = 0; mem_ready = 1;
    #2 rst = 0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
